// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write-port arbiter.
package regfile_pkg;
  localparam int NREQ = 3;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int PW   = 2;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_MDU  = 2;

  localparam logic [AW-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// Circular first-valid search starting at the pointer; returns one-hot grant and encoded index.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  int j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!any_o && valid_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU, load and MDU writeback.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = regfile_pkg::NREQ,
  parameter int AW   = regfile_pkg::AW,
  parameter int DW   = regfile_pkg::DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold_i,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  input  logic [NREQ*DW-1:0]   req_data_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic                 wr_en_o,
  output logic [AW-1:0]        wr_addr_o,
  output logic [DW-1:0]        wr_data_o,
  output logic [PW-1:0]        rr_ptr_o
);

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   wr_addr_q, wr_addr_d;
  logic [DW-1:0]   wr_data_q, wr_data_d;
  logic [NREQ-1:0] grant;
  logic [PW-1:0]   win_idx;
  logic            any_valid;
  logic            xfer;
  logic [AW-1:0]   win_addr;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (win_idx),
    .any_o   (any_valid)
  );

  // Reset and hold both mask the grant so no requester sees a transfer it will lose.
  assign req_ready_o = (reset || hold_i) ? '0 : grant;
  assign xfer        = any_valid && !hold_i && !reset;
  assign win_addr    = req_addr_i[win_idx*AW +: AW];

  always_comb begin
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (xfer) begin
      wr_addr_d = win_addr;
      wr_data_d = req_data_i[win_idx*DW +: DW];
      wr_en_d   = (win_addr != REG_ZERO);
      ptr_d     = (win_idx == PW'(NREQ-1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign rr_ptr_o  = ptr_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with hand-computed expectations.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               hold = 1'b0;
  logic [NREQ-1:0]    vld = '0;
  logic [NREQ*AW-1:0] addr = '0;
  logic [NREQ*DW-1:0] data = '0;
  logic [NREQ-1:0]    ready;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [PW-1:0]      ptr;

  int checks = 0;
  int failures = 0;

  regfile_wr_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .hold_i      (hold),
    .req_valid_i (vld),
    .req_addr_i  (addr),
    .req_data_i  (data),
    .req_ready_o (ready),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data),
    .rr_ptr_o    (ptr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW] = a;
    data[i*DW +: DW] = d;
  endtask

  task automatic check_wr(input string tag, input logic en, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [PW-1:0] p);
    check_eq({tag, "_wr_en"}, 32'(wr_en), 32'(en));
    check_eq({tag, "_wr_addr"}, 32'(wr_addr), 32'(a));
    check_eq({tag, "_wr_data"}, wr_data, d);
    check_eq({tag, "_ptr"}, 32'(ptr), 32'(p));
  endtask

  initial begin
    logic [2:0] oh;

    // Reset with every requester valid
    vld = 3'b111;
    set_req(REQ_ALU, 5'd5, 32'hDEADBEEF);
    set_req(REQ_LOAD, 5'd6, 32'h66666666);
    set_req(REQ_MDU, 5'd7, 32'h77777777);
    @(negedge clk); @(negedge clk);
    check_eq("rst_ready", 32'(ready), 32'(3'b000));
    check_wr("rst", 1'b0, 5'd0, 32'h0, 2'd0);

    // Release with only ALU valid
    reset = 1'b0;
    vld = 3'b001;
    #1;
    check_eq("first_ready", 32'(ready), 32'(3'b001));
    @(posedge clk); @(negedge clk);
    vld = 3'b000;
    check_wr("first", 1'b1, 5'd5, 32'hDEADBEEF, 2'd1);
    @(negedge clk);
    check_wr("idle", 1'b0, 5'd5, 32'hDEADBEEF, 2'd1);

    // Reset pulse returns pointer to 0, then full contention
    reset = 1'b1; #1; reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(10 + i), 32'hA0000000 + 32'(i));
    vld = 3'b111;
    #1;
    for (int c = 0; c < 6; c++) begin
      int w;
      w = c % 3;
      oh = 3'b001 << w;
      check_eq("cont_ready", 32'(ready), 32'(oh));
      check_eq("cont_ptr_pre", 32'(ptr), 32'(w));
      @(posedge clk); @(negedge clk);
      check_wr("cont", 1'b1, AW'(10 + w), 32'hA0000000 + 32'(w), PW'((w + 1) % 3));
    end
    vld = 3'b000;

    // Register-zero write from LOAD: consumed, not written, pointer still advances
    set_req(REQ_LOAD, 5'd0, 32'h12345678);
    vld = 3'b010;
    #1;
    check_eq("rz_ready", 32'(ready), 32'(3'b010));
    @(posedge clk); @(negedge clk);
    vld = 3'b000;
    check_wr("rz", 1'b0, 5'd0, 32'h12345678, 2'd2);

    // Hold with MDU and ALU valid: no grant, no pointer movement
    set_req(REQ_ALU, 5'd9, 32'h99990000);
    set_req(REQ_MDU, 5'd17, 32'hCAFEF00D);
    hold = 1'b1;
    vld = 3'b101;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("hold_ready", 32'(ready), 32'(3'b000));
      @(posedge clk); @(negedge clk);
      check_eq("hold_wr_en", 32'(wr_en), 32'(1'b0));
      check_eq("hold_ptr", 32'(ptr), 32'(2'd2));
    end
    hold = 1'b0;
    #1;
    check_eq("unhold_ready", 32'(ready), 32'(3'b100));
    @(posedge clk); @(negedge clk);
    check_wr("unhold", 1'b1, 5'd17, 32'hCAFEF00D, 2'd0);

    // ALU write in flight, then async reset between edges
    vld = 3'b001;
    #1;
    check_eq("pre_rst_ready", 32'(ready), 32'(3'b001));
    @(posedge clk); #2;
    check_eq("pre_rst_wr_en", 32'(wr_en), 32'(1'b1));
    hold = 1'b1;
    reset = 1'b1;
    #1;
    check_eq("arst_ready", 32'(ready), 32'(3'b000));
    check_wr("arst", 1'b0, 5'd0, 32'h0, 2'd0);
    @(negedge clk);
    hold = 1'b0;
    reset = 1'b0;
    #1;
    check_eq("regrant_ready", 32'(ready), 32'(3'b001));
    @(posedge clk); @(negedge clk);
    vld = 3'b000;
    check_wr("regrant", 1'b1, 5'd9, 32'h99990000, 2'd1);

    // Move pointer to 2 via LOAD, then wrap with ALU and MDU valid
    set_req(REQ_LOAD, 5'd3, 32'h33333333);
    vld = 3'b010;
    @(posedge clk); @(negedge clk);
    check_wr("to2", 1'b1, 5'd3, 32'h33333333, 2'd2);
    vld = 3'b101;
    #1;
    check_eq("wrap_ready0", 32'(ready), 32'(3'b100));
    @(posedge clk); @(negedge clk);
    check_wr("wrap0", 1'b1, 5'd17, 32'hCAFEF00D, 2'd0);
    vld = 3'b001;
    #1;
    check_eq("wrap_ready1", 32'(ready), 32'(3'b001));
    @(posedge clk); @(negedge clk);
    vld = 3'b000;
    check_wr("wrap1", 1'b1, 5'd9, 32'h99990000, 2'd1);
    #1;
    check_eq("end_ready", 32'(ready), 32'(3'b000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
